// File: rtl/delayed_value_checker.sv
// Self-check monitor: value must equal init right after start and exp DELAY cycles later.
// Optional early-change detection during the wait window: DVC_EARLY_CHANGE_CHECK_EN.
module delayed_value_checker #(
  parameter int WIDTH = 4,
  parameter int DELAY = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] exp_val,
  input  logic [WIDTH-1:0] value_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_CHK,
    S_WAIT,
    S_FINAL_CHK,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LOAD =
    (DELAY == 0) ? CNT_W'(1) : CNT_W'(DELAY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             ok_q, ok_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       code_q, code_d;
`ifdef DVC_EARLY_CHANGE_CHECK_EN
  logic [WIDTH-1:0] ref_q, ref_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = init_q;
    exp_d   = exp_q;
    ok_d    = ok_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    code_d  = code_q;
`ifdef DVC_EARLY_CHANGE_CHECK_EN
    ref_d   = ref_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          init_d  = init_val;
          exp_d   = exp_val;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          code_d  = 2'b00;
          state_d = S_INIT_CHK;
        end
      end
      S_INIT_CHK: begin
        if (value_in != init_q) begin
          fail_d  = 1'b1;
          code_d  = 2'b01;
          state_d = S_DONE;
        end else begin
          cnt_d   = LOAD;
`ifdef DVC_EARLY_CHANGE_CHECK_EN
          ref_d   = value_in;
`endif
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // final sample is taken on the edge the count expires
        if (cnt_q == CNT_W'(1)) begin
          ok_d    = (value_in == exp_q);
          state_d = S_FINAL_CHK;
        end
`ifdef DVC_EARLY_CHANGE_CHECK_EN
        else if (value_in != ref_q) begin
          fail_d  = 1'b1;
          code_d  = 2'b11;
          state_d = S_DONE;
        end
`endif
      end
      S_FINAL_CHK: begin
        if (ok_q) begin
          pass_d = 1'b1;
        end else begin
          fail_d = 1'b1;
          code_d = 2'b10;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      init_q  <= '0;
      exp_q   <= '0;
      ok_q    <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'b00;
`ifdef DVC_EARLY_CHANGE_CHECK_EN
      ref_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
      exp_q   <= exp_d;
      ok_q    <= ok_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
`ifdef DVC_EARLY_CHANGE_CHECK_EN
      ref_q   <= ref_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = code_q;

endmodule

// File: tb/tb_delayed_value_checker.sv
// Randomized self-checking bench for delayed_value_checker.
// Expected verdicts come from a trace-level model of the check rules.
module tb_delayed_value_checker;

  localparam int W = 4;
  localparam int D = 5;

  typedef logic [W-1:0] trace_t [16];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] init_val = '0;
  logic [W-1:0] exp_val = '0;
  logic [W-1:0] value_in = '0;
  logic         busy, done, pass, fail;
  logic [1:0]   fail_code;

  int vectors = 0;
  int miscompares = 0;

  delayed_value_checker #(.WIDTH(W), .DELAY(D), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .init_val(init_val), .exp_val(exp_val), .value_in(value_in),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  // tr[k] is the value present at start edge + k
  function automatic trace_t step(logic [W-1:0] a, logic [W-1:0] b, int at);
    trace_t t;
    for (int k = 0; k < 16; k++) t[k] = (k < at) ? a : b;
    return t;
  endfunction

  // k = edge index after which done is seen high
  function automatic void model(input logic [W-1:0] iv, input logic [W-1:0] ev,
                                input trace_t tr, output int k,
                                output logic p, output logic f,
                                output logic [1:0] c);
    p = 1'b0; f = 1'b0; c = 2'b00; k = D + 2;
    if (tr[1] !== iv) begin
      k = 1; f = 1'b1; c = 2'b01;
      return;
    end
`ifdef DVC_EARLY_CHANGE_CHECK_EN
    for (int j = 2; j <= D; j++)
      if (tr[j] !== tr[1]) begin
        k = j; f = 1'b1; c = 2'b11;
        return;
      end
`endif
    if (tr[D+1] === ev) p = 1'b1;
    else begin f = 1'b1; c = 2'b10; end
  endfunction

  // Drives one sequence; caller is positioned 1 time unit after a posedge.
  task automatic run_seq(input logic [W-1:0] iv, input logic [W-1:0] ev,
                         input trace_t tr, output int dk, output logic op,
                         output logic of, output logic [1:0] oc,
                         output int nd, output logic bb);
    dk = -1; op = 1'b0; of = 1'b0; oc = 2'b00; nd = 0; bb = 1'b0;
    init_val = iv; exp_val = ev; value_in = tr[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!busy) bb = 1'b1;
    for (int k = 1; k < 16; k++) begin
      value_in = tr[k];
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (dk < 0) begin
          dk = k; op = pass; of = fail; oc = fail_code;
        end
      end
      if (dk < 0 || k == dk) begin
        if (!busy) bb = 1'b1;
      end else if (k == dk + 1 && busy) bb = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, pass, fail, fail_code} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=000000",
               {busy, done, pass, fail, fail_code});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    trace_t tr;
    logic [W-1:0] iv, ev;
    int dk, nd, mk;
    logic op, of, bb, mp, mf;
    logic [1:0] oc, mc;
    string nm;
    for (int s = 0; s < 4; s++) begin
      iv = 4'd0; ev = 4'd1;
      case (s)
        0: begin nm = "nominal";      tr = step(4'd0, 4'd1, 5); end
        1: begin nm = "late_update";  tr = step(4'd0, 4'd1, 7); end
        2: begin nm = "init_mismatch"; tr = step(4'd0, 4'd3, 1); end
        default: begin nm = "early_change"; tr = step(4'd0, 4'd1, 3); end
      endcase
      model(iv, ev, tr, mk, mp, mf, mc);
      run_seq(iv, ev, tr, dk, op, of, oc, nd, bb);
      vectors++;
      if (dk !== mk || nd !== 1) begin
        miscompares++;
        $display("FAIL %s_done_edge got=%0d (count %0d) want=%0d (count 1)",
                 nm, dk, nd, mk);
      end
      vectors++;
      if ({op, of, oc} !== {mp, mf, mc}) begin
        miscompares++;
        $display("FAIL %s_verdict got p=%b f=%b c=%b want p=%b f=%b c=%b",
                 nm, op, of, oc, mp, mf, mc);
      end
      vectors++;
      if (bb !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busy got bad=%b want 0", nm, bb);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int dk, nd;
    logic op, of, bb;
    logic [1:0] oc;
    init_val = 4'd0; exp_val = 4'd1; value_in = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midwait_busy_before got=%b want=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, pass, fail, fail_code} !== 6'b0) begin
      miscompares++;
      $display("FAIL midwait_async_reset got=%b want=000000",
               {busy, done, pass, fail, fail_code});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seq(4'd0, 4'd1, step(4'd0, 4'd1, 5), dk, op, of, oc, nd, bb);
    vectors++;
    if (dk !== D + 2 || op !== 1'b1 || of !== 1'b0 || oc !== 2'b00) begin
      miscompares++;
      $display("FAIL after_reset_rerun got k=%0d p=%b f=%b c=%b want k=%0d p=1 f=0 c=00",
               dk, op, of, oc, D + 2);
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first, second;
    logic p9, b9, p_end;
    ndone = 0; first = -1; second = -1; p9 = 1'bx; b9 = 1'bx; p_end = 1'b0;
    init_val = 4'd0; exp_val = 4'd1; value_in = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      start = (k == 2 || k == 4 || k == 9);
      if (k >= 9) begin exp_val = 4'd0; value_in = 4'd0; end
      else value_in = (k >= 5) ? 4'd1 : 4'd0;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) first = k;
        else if (second < 0) begin second = k; p_end = pass; end
      end
      if (k == 9) begin p9 = pass; b9 = busy; end
    end
    start = 1'b0;
    vectors++;
    if (first !== D + 2 || ndone !== 2) begin
      miscompares++;
      $display("FAIL ignore_start got first=%0d dones=%0d want first=%0d dones=2",
               first, ndone, D + 2);
    end
    vectors++;
    if (p9 !== 1'b0 || b9 !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clears_pass got pass=%b busy=%b want 0 1", p9, b9);
    end
    vectors++;
    if (second !== 9 + D + 2 || p_end !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_verdict got k=%0d pass=%b want k=%0d pass=1",
               second, p_end, 9 + D + 2);
    end
  endtask

  task automatic test_back_to_back();
    int d[$];
    int guard;
    init_val = 4'd2; exp_val = 4'd2; value_in = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        d.push_back(k);
        vectors++;
        if (pass !== 1'b1) begin
          miscompares++;
          $display("FAIL held_start_pass at k=%0d got=%b want=1", k, pass);
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (d.size() != 2 || d[0] != D + 2 || d[1] != 2 * (D + 2) + 2) begin
      miscompares++;
      $display("FAIL held_start_dones got n=%0d want 2 at %0d,%0d",
               d.size(), D + 2, 2 * (D + 2) + 2);
    end
    guard = 0;
    while (busy && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_timeout busy=%b want=0", busy);
    end
  endtask

  task automatic test_random();
    trace_t tr;
    logic [W-1:0] iv, ev;
    int dk, nd, mk, mode;
    logic op, of, bb, mp, mf;
    logic [1:0] oc, mc;
    for (int n = 0; n < 40; n++) begin
      iv = W'($urandom); ev = W'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: tr = step(iv, ev, D + 1);
        1: tr = step(iv, ev, $urandom_range(2, D + 3));
        2: begin tr = step(iv, ev, D + 1); tr[1] = W'($urandom); end
        default: begin tr = step(iv, ev, D + 1); tr[D+1] = W'($urandom); end
      endcase
      model(iv, ev, tr, mk, mp, mf, mc);
      run_seq(iv, ev, tr, dk, op, of, oc, nd, bb);
      vectors++;
      if (dk !== mk || nd !== 1 || bb !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_timing got k=%0d n=%0d bb=%b want k=%0d n=1 bb=0",
                 n, dk, nd, bb, mk);
      end
      vectors++;
      if ({op, of, oc} !== {mp, mf, mc}) begin
        miscompares++;
        $display("FAIL rand%0d_verdict got p=%b f=%b c=%b want p=%b f=%b c=%b",
                 n, op, of, oc, mp, mf, mc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_wait();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delayed_value_checker.md
Name: delayed_value_checker

Overview:
- Clocked self-check stage that consumes a register value driven by an upstream delayed-assignment block.
- The upstream block loads a value, waits a fixed delay, then publishes it.
- This block verifies two things: the value equals an initial value immediately after a start pulse, and it equals an expected value exactly DELAY cycles later.
- It reports a sticky pass/fail verdict with a failure code, replacing ad-hoc initial-block checks with a reusable synthesizable monitor.

Parameters:
- WIDTH, 4, width of the monitored value and comparison operands.
- DELAY, 5, cycles from the initial check to the final check; legal range 1..2^CNT_W-1; 0 is treated as 1.
- CNT_W, 8, delay counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a check sequence; sampled only in IDLE.
- init_val  input  WIDTH  value required at the initial check; captured at start.
- exp_val  input  WIDTH  value required at the final check; captured at start.
- value_in  input  WIDTH  monitored value from the upstream stage.
- busy  output  1  high from the cycle after start until DONE is left.
- done  output  1  one-cycle pulse when the verdict is posted.
- pass  output  1  sticky; set on success; cleared by next accepted start or reset.
- fail  output  1  sticky; set on any failure; cleared by next accepted start or reset.
- fail_code  output  2  00 none, 01 initial mismatch, 10 final mismatch, 11 early change (optional feature only).

Behaviour:
- Reset is asynchronous, active-low, one clock domain. While rst_n=0: state=IDLE, counter=0, busy=0, done=0, pass=0, fail=0, fail_code=00, captured operands=0.
- A reset asserted mid-sequence aborts the sequence with no verdict.
- FSM states: IDLE, INIT_CHK, WAIT, FINAL_CHK, DONE.
- IDLE:
  - On an edge with start=1: capture init_val/exp_val, clear pass/fail/fail_code, go to INIT_CHK.
  - busy rises in the same cycle.
- INIT_CHK (edge T+1, where T is the start edge):
  - value_in != captured init → fail=1, fail_code=01, go to DONE.
  - Otherwise load counter=DELAY (1 if DELAY==0), latch value_in as the reference value, go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - When the counter equals 1 at an edge, go to FINAL_CHK.
  - The final comparison therefore occurs at edge T+1+DELAY.
- FINAL_CHK:
  - value_in == captured exp → pass=1.
  - Otherwise fail=1, fail_code=10.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0 on exit.
  - Return to IDLE on the next edge.
  - pass/fail/fail_code hold.
- start while not in IDLE (including DONE) is ignored; no queueing.
- start held high continuously: a new sequence begins on each IDLE visit; the verdict remains visible during its DONE cycle.
- pass and fail are never both 1.
- All comparisons are exact, WIDTH-bit, unsigned; no X-propagation handling in RTL.
- Latency from start edge to done pulse: DELAY+3 edges on success and on final mismatch; 2 edges on initial mismatch.

Optional Feature:
- Macro DVC_EARLY_CHANGE_CHECK_EN.
- When defined: during WAIT, any edge where value_in differs from the reference value latched in INIT_CHK sets fail=1 and fail_code=11, and goes straight to DONE. This catches an upstream stage that publishes before its delay elapses.
- When undefined: value_in is ignored during WAIT, and code 11 is never produced.

Test Plan:
- Nominal (WIDTH=4, DELAY=5): init_val=0, exp_val=1; value_in=0 until edge T+5, then 1 → done pulse at T+8, pass=1, fail=0, fail_code=00.
- Late update: same stimulus, but value_in changes to 1 at edge T+7 → fail=1, fail_code=10, done at T+8.
- Initial mismatch: value_in=3 at T+1 with init_val=0 → fail=1, fail_code=01, done at T+2, busy low at T+3.
- Early change: value_in goes to 1 at T+3 → with DVC_EARLY_CHANGE_CHECK_EN, fail_code=11 and done at T+4; without it, pass=1 at T+8.
- Reset mid-WAIT: assert rst_n=0 between edges at T+3 → all outputs 0 immediately. A new start after release runs the full sequence to pass.
- Start while busy: pulse start at T+2 and T+4 → ignored; single done at T+8. A start at T+9 in IDLE clears pass and starts a new sequence.
